// File: rtl/instr_mem_loadable.sv
// Byte-addressed instruction memory with a serial ready/valid byte loader
// and a one-cycle registered word read port for the fetch stage.
module instr_mem_loadable #(
  parameter int NB_BYTE    = 8,
  parameter int NB_INST    = 32,
  parameter int DEPTH      = 256,
  parameter int NB_ADDR    = $clog2(DEPTH),
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_load_start,
  input  logic                 i_load_valid,
  input  logic [NB_BYTE-1:0]   i_load_byte,
  input  logic                 i_load_end,
  output logic                 o_load_ready,
  output logic                 o_load_overflow,
  output logic [NB_ADDR:0]     o_prog_size,
  input  logic                 i_rd_en,
  input  logic [NB_ADDR-1:0]   i_addr,
  output logic [NB_INST-1:0]   o_data,
  output logic                 o_rd_valid,
  output logic                 o_rd_err
);

  localparam int BPW = NB_INST / NB_BYTE;
  localparam logic [NB_ADDR:0] DEPTH_C = (NB_ADDR + 1)'(DEPTH);
  localparam logic [NB_ADDR:0] LAST_C  = (NB_ADDR + 1)'(DEPTH - 1);
  localparam logic [NB_ADDR:0] SPAN_C  = (NB_ADDR + 1)'(BPW - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t               state, state_nxt;
  logic [NB_BYTE-1:0]   mem [DEPTH];
  logic                 clr_load;
  logic                 accept;
  logic                 full_hit;
  logic [NB_ADDR-1:0]   wr_ptr;

  logic                 rd_acc_p0;
  logic                 rd_bad_p0;
  logic [NB_INST-1:0]   rd_word_p0;

  // The write pointer always equals the accepted-byte count while loading.
  assign wr_ptr = o_prog_size[NB_ADDR-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    clr_load     = 1'b0;
    o_load_ready = (state == LOAD) && (o_prog_size < DEPTH_C);
    accept       = 1'b0;
    full_hit     = 1'b0;
    if (i_load_start) begin
      state_nxt = LOAD;
      clr_load  = 1'b1;
    end else if (state == LOAD) begin
      accept   = i_load_valid && o_load_ready;
      full_hit = i_load_valid && !o_load_ready;
      if (i_load_end) state_nxt = DONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_prog_size     <= '0;
      o_load_overflow <= 1'b0;
    end else if (clr_load) begin
      o_prog_size     <= '0;
      o_load_overflow <= 1'b0;
    end else begin
      if (accept)   o_prog_size     <= o_prog_size + 1'b1;
      if (full_hit) o_load_overflow <= 1'b1;
    end
  end

  // Array is never reset so a program survives a debug-side reset.
  always_ff @(posedge i_clk) begin
    if (accept) mem[wr_ptr] <= i_load_byte;
  end

  // Stage p0: address checks and word assembly from the byte array
  always_comb begin
    rd_acc_p0  = i_rd_en && (state != LOAD);
    rd_bad_p0  = ((i_addr % NB_ADDR'(BPW)) != '0) ||
                 (({1'b0, i_addr} + SPAN_C) > LAST_C);
    rd_word_p0 = '0;
    for (int i = 0; i < BPW; i++) begin
      if (BIG_ENDIAN)
        rd_word_p0[(BPW-1-i)*NB_BYTE +: NB_BYTE] = mem[i_addr + NB_ADDR'(i)];
      else
        rd_word_p0[i*NB_BYTE +: NB_BYTE] = mem[i_addr + NB_ADDR'(i)];
    end
  end

  // Stage p1: registered read outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data     <= '0;
      o_rd_valid <= 1'b0;
      o_rd_err   <= 1'b0;
    end else begin
      o_rd_valid <= rd_acc_p0;
      o_rd_err   <= rd_acc_p0 && rd_bad_p0;
      if (rd_acc_p0) o_data <= rd_bad_p0 ? '0 : rd_word_p0;
    end
  end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed bench: a default big-endian 256-byte instance and a little-endian
// 16-byte instance share the same loader and read stimulus.
module tb_instr_mem_loadable;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start, load_valid, load_end, rd_en;
  logic [7:0]  load_byte;
  logic [7:0]  addr;

  logic        a_ready, a_ovf, a_rd_valid, a_rd_err;
  logic [8:0]  a_size;
  logic [31:0] a_data;
  logic        b_ready, b_ovf, b_rd_valid, b_rd_err;
  logic [4:0]  b_size;
  logic [31:0] b_data;

  int vectors = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  instr_mem_loadable dut_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_load_start(load_start), .i_load_valid(load_valid),
    .i_load_byte(load_byte), .i_load_end(load_end),
    .o_load_ready(a_ready), .o_load_overflow(a_ovf), .o_prog_size(a_size),
    .i_rd_en(rd_en), .i_addr(addr),
    .o_data(a_data), .o_rd_valid(a_rd_valid), .o_rd_err(a_rd_err)
  );

  instr_mem_loadable #(.DEPTH(16), .BIG_ENDIAN(1'b0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_load_start(load_start), .i_load_valid(load_valid),
    .i_load_byte(load_byte), .i_load_end(load_end),
    .o_load_ready(b_ready), .o_load_overflow(b_ovf), .o_prog_size(b_size),
    .i_rd_en(rd_en), .i_addr(addr[3:0]),
    .o_data(b_data), .o_rd_valid(b_rd_valid), .o_rd_err(b_rd_err)
  );

  typedef struct {
    logic [7:0]  addr;
    logic        chk_a_data;
    logic [31:0] a_data;
    logic        a_err;
    logic        chk_b;
    logic [31:0] b_data;
    logic        b_err;
  } rd_vec_t;

  rd_vec_t     rd_tab [5];
  logic [7:0]  prog [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    load_valid = 1'b1;
    load_byte  = b;
    step();
    load_valid = 1'b0;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  task automatic pulse_end();
    load_end = 1'b1;
    step();
    load_end = 1'b0;
  endtask

  task automatic read_word(input logic [7:0] a);
    addr  = a;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  initial begin
    prog = '{8'h01, 8'h2A, 8'h58, 8'h21, 8'h3C, 8'h09, 8'h00, 8'h01};
    rd_tab[0] = '{8'd2,   1'b1, 32'h0,        1'b1, 1'b1, 32'h0,        1'b1};
    rd_tab[1] = '{8'd253, 1'b1, 32'h0,        1'b1, 1'b1, 32'h0,        1'b1};
    rd_tab[2] = '{8'd252, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0};
    rd_tab[3] = '{8'd0,   1'b1, 32'h012A5821, 1'b0, 1'b1, 32'h21582A01, 1'b0};
    rd_tab[4] = '{8'd4,   1'b1, 32'h3C090001, 1'b0, 1'b1, 32'h0100093C, 1'b0};

    rst_n = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_end = 1'b0;
    load_byte = '0; rd_en = 1'b0; addr = '0;
    step(); step();
    chk("rst_data",     a_data,            32'h0);
    chk("rst_rd_valid", 32'(a_rd_valid),   32'h0);
    chk("rst_rd_err",   32'(a_rd_err),     32'h0);
    chk("rst_ready",    32'(a_ready),      32'h0);
    chk("rst_ovf",      32'(a_ovf),        32'h0);
    chk("rst_size",     32'(a_size),       32'h0);
    rst_n = 1'b1;
    step();

    // Program load of eight bytes.
    pulse_start();
    chk("load_ready", 32'(a_ready), 32'h1);
    for (int i = 0; i < 8; i++) send_byte(prog[i]);
    pulse_end();
    chk("a_size8",    32'(a_size),  32'd8);
    chk("b_size8",    32'(b_size),  32'd8);
    chk("done_ready", 32'(a_ready), 32'h0);

    // Back-to-back reads straight from the table.
    for (int i = 0; i < 5; i++) begin
      addr  = rd_tab[i].addr;
      rd_en = 1'b1;
      step();
      chk($sformatf("a_vld[%0d]", i), 32'(a_rd_valid), 32'h1);
      chk($sformatf("a_err[%0d]", i), 32'(a_rd_err), 32'(rd_tab[i].a_err));
      if (rd_tab[i].chk_a_data)
        chk($sformatf("a_data[%0d]", i), a_data, rd_tab[i].a_data);
      if (rd_tab[i].chk_b) begin
        chk($sformatf("b_err[%0d]", i),  32'(b_rd_err), 32'(rd_tab[i].b_err));
        chk($sformatf("b_data[%0d]", i), b_data, rd_tab[i].b_data);
      end
    end
    rd_en = 1'b0;
    step();
    chk("vld_pulse", 32'(a_rd_valid), 32'h0);
    chk("data_hold", a_data, 32'h3C090001);

    // Read blocked during LOAD, then restart after three bytes.
    pulse_start();
    read_word(8'd0);
    chk("ld_rd_valid", 32'(a_rd_valid), 32'h0);
    chk("ld_rd_err",   32'(a_rd_err),   32'h0);
    chk("ld_rd_hold",  a_data,          32'h3C090001);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    chk("size3", 32'(a_size), 32'd3);
    pulse_start();
    chk("restart_size", 32'(a_size), 32'd0);
    send_byte(8'h55);
    pulse_end();
    chk("restart_size1", 32'(a_size), 32'd1);
    read_word(8'd0);
    chk("restart_a", a_data, 32'h55BBCC21);
    chk("restart_b", b_data, 32'h21CCBB55);

    // Fill the 16-byte instance and offer a 17th byte.
    pulse_start();
    for (int i = 0; i < 16; i++) send_byte(8'h80 + 8'(i));
    chk("full_ready", 32'(b_ready), 32'h0);
    chk("full_size",  32'(b_size),  32'd16);
    chk("full_ovf0",  32'(b_ovf),   32'h0);
    send_byte(8'hF0);
    chk("ovf_flag",   32'(b_ovf),   32'h1);
    chk("ovf_size",   32'(b_size),  32'd16);
    chk("a_size17",   32'(a_size),  32'd17);
    chk("a_no_ovf",   32'(a_ovf),   32'h0);
    pulse_end();
    read_word(8'd0);
    chk("ovf_mem0_b", b_data, 32'h83828180);
    chk("ovf_mem0_a", a_data, 32'h80818283);

    // Simultaneous start and end: start wins with cleared counters.
    load_start = 1'b1; load_end = 1'b1;
    step();
    load_start = 1'b0; load_end = 1'b0;
    chk("se_ready",  32'(a_ready), 32'h1);
    chk("se_size",   32'(a_size),  32'd0);
    chk("se_b_ovf",  32'(b_ovf),   32'h0);

    // Asynchronous reset in the middle of a load keeps written bytes.
    send_byte(8'hDE); send_byte(8'hAD);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(a_ready),    32'h0);
    chk("mid_rst_size",  32'(a_size),     32'h0);
    chk("mid_rst_data",  a_data,          32'h0);
    chk("mid_rst_vld",   32'(a_rd_valid), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    read_word(8'd0);
    chk("mid_rst_mem", a_data, 32'hDEAD8283);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
